ecc_err_log: RTL

Error-event logger and statistics block that sits directly downstream of the extended-Hamming decoder. It samples the decoder's syndrome and error flags together with the memory address of the word just decoded. It keeps saturating single- and double-bit error counters and queues per-event records in a show-ahead FIFO for software or a scrubber to drain. It also raises a sticky interrupt on uncorrectable errors or record loss.

---
 rtl/ecc_err_log.sv | 105 ++++++++++
 1 files changed

// File: rtl/ecc_err_log.sv
// ecc_err_log: ECC error-event logger with saturating counters, show-ahead record FIFO and sticky irq
//   clk_i/rst_i/clkena_i : rising-edge clock, synchronous active-high reset, clock enable
//   valid_i, addr_i, syndrome_i, sb_err_i, db_err_i, sb_fix_i : decoder result for one word
//   rd_en_i, clr_cnt_i, irq_clr_i : pop head record, clear counters, clear irq/overflow
//   rec_*_o, level_o : head record and FIFO occupancy
//   sb_cnt_o, db_cnt_o, overflow_o, irq_o : statistics and sticky flags
package ecc_err_log_pkg;
    function automatic int calculate_m(input int k);
        int m;
        m = 1;
        while ((1 << m) < k + m + 1) m++;
        return m;
    endfunction
endpackage

module ecc_err_log
    import ecc_err_log_pkg::*;
#(
    parameter int K      = 8,
    parameter int M      = calculate_m(K),
    parameter bit P0_LSB = 1'b1,
    parameter int AW     = 16,
    parameter int DEPTH  = 8,
    parameter int CW     = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clkena_i,
    input  logic                     valid_i,
    input  logic [AW-1:0]            addr_i,
    input  logic [M:0]               syndrome_i,
    input  logic                     sb_err_i,
    input  logic                     db_err_i,
    input  logic                     sb_fix_i,
    input  logic                     rd_en_i,
    input  logic                     clr_cnt_i,
    input  logic                     irq_clr_i,
    output logic                     rec_valid_o,
    output logic [AW-1:0]            rec_addr_o,
    output logic [M:0]               rec_syndrome_o,
    output logic                     rec_db_o,
    output logic                     rec_fix_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [CW-1:0]            sb_cnt_o,
    output logic [CW-1:0]            db_cnt_o,
    output logic                     overflow_o,
    output logic                     irq_o
);
    localparam int PW = $clog2(DEPTH) + 1;
    localparam int RW = AW + M + 3;

    logic [RW-1:0] mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic          p;
    logic [M-1:0]  s;
    logic          active, sb_ev, db_ev, ev, empty, full, pop, push, drop, clr;

    assign p = P0_LSB ? syndrome_i[0] : syndrome_i[M];
    assign s = P0_LSB ? syndrome_i[M:1] : syndrome_i[M-1:0];

    // A lone overall-parity flip (p set, S zero) is a single-bit error the decoder does not flag.
    assign active = valid_i & clkena_i;
    assign db_ev  = active & db_err_i;
    assign sb_ev  = active & ~db_err_i & (sb_err_i | (p & (s == '0)));
    assign ev     = sb_ev | db_ev;

    // Extra pointer MSB distinguishes full from empty.
    assign level_o = wp - rp;
    assign empty   = wp == rp;
    assign full    = level_o == PW'(DEPTH);
    assign pop     = clkena_i & rd_en_i & ~empty;
    assign push    = ev & (~full | pop);
    assign drop    = ev & full & ~pop;
    assign clr     = clkena_i & clr_cnt_i;

    assign rec_valid_o = ~empty;
    assign {rec_addr_o, rec_syndrome_o, rec_db_o, rec_fix_o} = empty ? '0 : mem[rp[PW-2:0]];

    // Clear wins over the old value but a coincident event still counts as one.
    function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] c, input logic e, input logic cl);
        return cl ? {{(CW-1){1'b0}}, e} : (e && c != '1) ? c + 1'b1 : c;
    endfunction

    always_ff @(posedge clk_i) begin
        if (push) mem[wp[PW-2:0]] <= {addr_i, syndrome_i, db_ev, sb_fix_i & sb_ev};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wp         <= '0;
            rp         <= '0;
            sb_cnt_o   <= '0;
            db_cnt_o   <= '0;
            overflow_o <= 1'b0;
            irq_o      <= 1'b0;
        end else if (clkena_i) begin
            wp         <= wp + PW'(push);
            rp         <= rp + PW'(pop);
            sb_cnt_o   <= cnt_next(sb_cnt_o, sb_ev, clr);
            db_cnt_o   <= cnt_next(db_cnt_o, db_ev, clr);
            overflow_o <= drop | (overflow_o & ~irq_clr_i);
            irq_o      <= db_ev | drop | (irq_o & ~irq_clr_i);
        end
    end
endmodule
